// File: rtl/mem_access_pkg.sv
// Shared opcodes, bus request bundle and decode helpers for the MEM stage.
// Pure declarations: no latency, no flow control.
package mem_access_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Big-endian lane select and sign/zero extension of a read word.
// Combinational, no flow control.
module load_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [5:0]  i_opcode,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
        case (i_opcode)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'd0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: one load/store bus transfer per instruction, result pulsed to write-back.
// Latency 1 cycle (non-memory/misaligned) or 2+ cycles (bus); in_ready low while waiting.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        out_valid,
    output logic [31:0] WBdata,
    output logic [31:0] WBins,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [31:0] r_ins;
    logic [1:0]  r_lo;
    logic        r_req;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_out_valid;
    logic [31:0] r_wbdata;
    logic        r_addr_err;
    logic        r_bus_err;

    logic [5:0]  w_op;
    logic        w_accept;
    logic        w_mem;
    logic        w_mis;
    logic        w_timeout;
    bus_req_t    w_req;
    logic [31:0] w_load;

    always_comb begin
        w_op        = Ins[31:26];
        w_accept    = in_valid && (r_state == IDLE);
        w_mem       = is_mem(w_op);
        w_mis       = is_misaligned(w_op, Result[1:0]);
        // Ack on the same edge as the last counted cycle takes priority.
        w_timeout   = (r_state == WAIT) && !dmem_ack && (r_cnt == CNT_LAST);
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_mem && !w_mis) w_state_nxt = WAIT;
            WAIT:    if (dmem_ack || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_req.we    = is_store(w_op);
        w_req.addr  = {Result[31:2], 2'b00};
        w_req.be    = 4'b1111;
        w_req.wdata = '0;
        case (w_op)
            OP_SB: begin
                w_req.be    = 4'b1000 >> Result[1:0];
                w_req.wdata = {4{Rdata2[7:0]}};
            end
            OP_SH: begin
                w_req.be    = 4'b1100 >> Result[1:0];
                w_req.wdata = {2{Rdata2[15:0]}};
            end
            OP_SW:   w_req.wdata = Rdata2;
            default: ;
        endcase
    end

    load_align u_load_align (
        .i_addr_lo (r_lo),
        .i_opcode  (r_ins[31:26]),
        .i_rdata   (dmem_rdata),
        .o_data    (w_load)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ins       <= '0;
            r_lo        <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_out_valid <= 1'b0;
            r_wbdata    <= '0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= 1'b0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
            if (w_accept) begin
                r_ins <= Ins;
                r_lo  <= Result[1:0];
                r_cnt <= '0;
                if (!w_mem) begin
                    r_out_valid <= 1'b1;
                    r_wbdata    <= Result;
                end else if (w_mis) begin
                    r_out_valid <= 1'b1;
                    r_addr_err  <= 1'b1;
                    r_wbdata    <= '0;
                end else begin
                    r_req   <= 1'b1;
                    r_we    <= w_req.we;
                    r_be    <= w_req.be;
                    r_addr  <= w_req.addr;
                    r_wdata <= w_req.wdata;
                end
            end else if (r_state == WAIT) begin
                if (dmem_ack || w_timeout) begin
                    r_req       <= 1'b0;
                    r_we        <= 1'b0;
                    r_be        <= '0;
                    r_out_valid <= 1'b1;
                    r_bus_err   <= !dmem_ack;
                    r_wbdata    <= (dmem_ack && is_load(r_ins[31:26])) ? w_load : 32'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_be    = r_be;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign out_valid  = r_out_valid;
    assign WBdata     = r_wbdata;
    assign WBins      = r_ins;
    assign addr_err   = r_addr_err;
    assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// Randomized transactions against a cycle-scheduled behavioural model, plus directed cases.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int T = 16;
    localparam logic [5:0] OP_ADDI = 6'h08;

    logic        CLK, RST, in_valid, in_ready;
    logic [31:0] Ins, Result, Rdata2;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        out_valid, addr_err, bus_err;
    logic [31:0] WBdata, WBins;

    mem_access #(.TIMEOUT(T)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .out_valid(out_valid), .WBdata(WBdata), .WBins(WBins),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
    } req_t;

    typedef struct {
        logic [31:0] wb;
        logic [31:0] ins;
        bit          ae;
        bit          berr;
    } out_t;

    req_t exp_req[int];
    out_t exp_out[int];
    bit   exp_busy[int];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   chk_en = 0;

    int          obs_cyc;
    logic [31:0] obs_wb;
    bit          obs_ae, obs_berr, obs_we, obs_req_seen;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd;
    req_t        cmp_r;
    out_t        cmp_o;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    function automatic bit m_is_mem(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic bit m_is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic bit m_mis(input logic [5:0] op, input logic [1:0] lo);
        if (op inside {OP_LH, OP_LHU, OP_SH}) return (int'(lo) % 2) != 0;
        if (op inside {OP_LW, OP_SW})         return int'(lo) != 0;
        return 0;
    endfunction

    // Byte k of a big-endian word sits 8*(3-k) bits above bit 0.
    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [1:0] lo,
                                           input logic [31:0] rd);
        int unsigned v;
        if (op == OP_LB || op == OP_LBU) begin
            v = (rd >> (8 * (3 - int'(lo)))) % 256;
            if (op == OP_LB && v >= 128) v = v + 32'hFFFFFF00;
        end else if (op == OP_LH || op == OP_LHU) begin
            v = (rd >> (8 * (2 - int'(lo)))) % 65536;
            if (op == OP_LH && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic req_t m_req(input logic [5:0] op, input logic [31:0] addr,
                                   input logic [31:0] d2);
        req_t r;
        int   lo;
        lo       = int'(addr[1:0]);
        r.addr   = addr & 32'hFFFFFFFC;
        r.we     = op inside {OP_SB, OP_SH, OP_SW};
        r.chk_wd = r.we;
        r.be     = 4'hF;
        r.wdata  = d2;
        if (op == OP_SB) begin
            r.be    = 4'(1 << (3 - lo));
            r.wdata = 32'(d2[7:0]) * 32'h01010101;
        end else if (op == OP_SH) begin
            r.be    = 4'(3 << (2 - lo));
            r.wdata = 32'(d2[15:0]) * 32'h00010001;
        end
        return r;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            chk1("in_ready", in_ready, !exp_busy.exists(cyc));
            if (exp_req.exists(cyc)) begin
                cmp_r = exp_req[cyc];
                chk1("dmem_req", dmem_req, 1'b1);
                chk1("dmem_we", dmem_we, cmp_r.we);
                chk("dmem_be", 32'(dmem_be), 32'(cmp_r.be));
                chk("dmem_addr", dmem_addr, cmp_r.addr);
                if (cmp_r.chk_wd) chk("dmem_wdata", dmem_wdata, cmp_r.wdata);
                obs_req_seen = 1;
                obs_be = dmem_be;
                obs_wd = dmem_wdata;
                obs_we = dmem_we;
            end else begin
                chk1("dmem_req_idle", dmem_req, 1'b0);
            end
            if (exp_out.exists(cyc)) begin
                cmp_o = exp_out[cyc];
                chk1("out_valid", out_valid, 1'b1);
                chk("WBdata", WBdata, cmp_o.wb);
                chk("WBins", WBins, cmp_o.ins);
                chk1("addr_err", addr_err, cmp_o.ae);
                chk1("bus_err", bus_err, cmp_o.berr);
                obs_cyc  = cyc;
                obs_wb   = WBdata;
                obs_ae   = addr_err;
                obs_berr = bus_err;
            end else begin
                chk1("out_valid_quiet", out_valid, 1'b0);
            end
        end
    end

    // k = WAIT cycle in which ack is driven (1 = first); outside 1..T means never.
    task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] d2,
                           input int k, input logic [31:0] rdata, input int gap, output int acc);
        logic [31:0] ins;
        bit   mem, mis, acked;
        int   endc;
        req_t r;
        out_t o;
        ins   = {op, 26'($urandom)};
        acc   = cyc + 1;
        mem   = m_is_mem(op);
        mis   = m_mis(op, addr[1:0]);
        acked = (k >= 1 && k <= T);
        endc  = acked ? k : T;
        o.ins = ins; o.ae = 0; o.berr = 0; o.wb = 32'd0;
        if (!mem) begin
            o.wb = addr;
            exp_out[acc] = o;
        end else if (mis) begin
            o.ae = 1;
            exp_out[acc] = o;
        end else begin
            r = m_req(op, addr, d2);
            for (int c = 1; c <= endc; c++) begin
                exp_req[acc + c - 1]  = r;
                exp_busy[acc + c - 1] = 1;
            end
            if (acked) o.wb = m_is_load(op) ? m_load(op, addr[1:0], rdata) : 32'd0;
            else       o.berr = 1;
            exp_out[acc + endc] = o;
        end
        in_valid = 1'b1; Ins = ins; Result = addr; Rdata2 = d2;
        dmem_ack = 1'($urandom); dmem_rdata = $urandom;
        @(posedge CLK); #1;
        in_valid = 1'b0; Ins = $urandom; Result = $urandom; Rdata2 = $urandom;
        dmem_ack = 1'b0;
        if (mem && !mis) begin
            for (int c = 1; c <= endc; c++) begin
                dmem_ack   = (c == k);
                dmem_rdata = (c == k) ? rdata : $urandom;
                @(posedge CLK); #1;
            end
        end
        dmem_ack = 1'b0;
        for (int g = 0; g < gap; g++) begin
            dmem_ack = 1'($urandom);
            @(posedge CLK); #1;
        end
        dmem_ack = 1'b0;
    endtask

    task automatic clear_obs();
        obs_cyc = -1; obs_wb = 'x; obs_ae = 0; obs_berr = 0;
        obs_req_seen = 0; obs_be = 'x; obs_wd = 'x; obs_we = 0;
    endtask

    task automatic settle();
        @(negedge CLK); #1;
    endtask

    task automatic resync();
        @(posedge CLK); #1;
    endtask

    initial begin
        int          acc;
        logic [5:0]  ops [10];
        logic [5:0]  op;
        logic [31:0] addr;
        int          k, sel;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADDI, 6'h00};

        RST = 1'b1; in_valid = 1'b0; Ins = '0; Result = '0; Rdata2 = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #2;
        chk1("rst_dmem_req", dmem_req, 1'b0);
        chk1("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_addr_err", addr_err, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk("rst_WBdata", WBdata, 32'd0);
        chk("rst_WBins", WBins, 32'd0);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        chk_en = 1;

        clear_obs();
        run_txn(OP_LW, 32'h100, $urandom, 3, 32'hDEADBEEF, 0, acc);
        settle();
        chk("lw_wbdata", obs_wb, 32'hDEADBEEF);
        chk("lw_latency", 32'(obs_cyc - acc + 1), 32'd4);
        resync();

        clear_obs();
        run_txn(OP_LW, 32'h104, $urandom, 1, 32'h01234567, 0, acc);
        settle();
        chk("lw_min_latency", 32'(obs_cyc - acc + 1), 32'd2);
        resync();

        clear_obs();
        run_txn(OP_LB, 32'h103, $urandom, 1, 32'h000000F0, 0, acc);
        settle();
        chk("lb_sext", obs_wb, 32'hFFFFFFF0);
        resync();

        clear_obs();
        run_txn(OP_LBU, 32'h103, $urandom, 1, 32'h000000F0, 0, acc);
        settle();
        chk("lbu_zext", obs_wb, 32'h000000F0);
        resync();

        clear_obs();
        run_txn(OP_SH, 32'h102, 32'h1234ABCD, 2, $urandom, 0, acc);
        settle();
        chk("sh_be", 32'(obs_be), 32'h3);
        chk("sh_wdata", obs_wd, 32'hABCDABCD);
        chk1("sh_we", obs_we, 1'b1);
        chk("sh_wbdata", obs_wb, 32'd0);
        resync();

        clear_obs();
        run_txn(OP_LW, 32'h101, $urandom, 1, $urandom, 0, acc);
        settle();
        chk1("mis_addr_err", obs_ae, 1'b1);
        chk1("mis_no_req", obs_req_seen, 1'b0);
        chk("mis_latency", 32'(obs_cyc - acc + 1), 32'd1);
        chk("mis_wbdata", obs_wb, 32'd0);
        resync();

        clear_obs();
        run_txn(OP_ADDI, 32'h55, $urandom, 1, $urandom, 0, acc);
        settle();
        chk("addi_wbdata", obs_wb, 32'h55);
        chk("addi_latency", 32'(obs_cyc - acc + 1), 32'd1);
        resync();

        clear_obs();
        run_txn(OP_LW, 32'h200, $urandom, 0, $urandom, 0, acc);
        settle();
        chk1("timeout_bus_err", obs_berr, 1'b1);
        chk("timeout_wait_cycles", 32'(obs_cyc - acc), 32'd16);
        resync();

        clear_obs();
        run_txn(OP_LW, 32'h204, $urandom, T, 32'hCAFEF00D, 0, acc);
        settle();
        chk1("tie_no_bus_err", obs_berr, 1'b0);
        chk("tie_wbdata", obs_wb, 32'hCAFEF00D);
        resync();

        // Reset in the middle of a transfer, then a late ack.
        chk_en = 0;
        in_valid = 1'b1; Ins = {OP_LW, 26'd0}; Result = 32'h300; Rdata2 = '0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        chk1("pre_rst_req", dmem_req, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk1("rst_async_req", dmem_req, 1'b0);
        chk1("rst_async_ready", in_ready, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b0;
        dmem_ack = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk1("late_ack_out_valid", out_valid, 1'b0);
            chk1("late_ack_req", dmem_req, 1'b0);
        end
        @(posedge CLK); #1;
        dmem_ack = 1'b0;
        exp_req.delete(); exp_out.delete(); exp_busy.delete();
        chk_en = 1;

        repeat (300) begin
            sel = $urandom_range(0, 10);
            op  = (sel == 10) ? 6'($urandom) : ops[sel];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op inside {OP_LW, OP_SW}) addr[1:0] = 2'b00;
                else addr[0] = 1'b0;
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      k = 0;
            else if (sel == 1) k = T;
            else if (sel == 2) k = T - 1;
            else               k = $urandom_range(1, 4);
            run_txn(op, addr, $urandom, k, $urandom, $urandom_range(0, 2), acc);
        end

        repeat (3) @(posedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
